ring_sequence_monitor: RTL and testbench
========================================

Name: ring_sequence_monitor

Overview:
- Receive-side checker for the one-hot ring counter bus: samples a WIDTH-bit ring state, verifies legal one-hot rotation, decodes the hot position to a binary index, and counts revolutions and sequence errors.
- Sits downstream of the ring counter group. It gives the design self-checking lock/error status and a compact binary position for downstream logic.

Parameters:
- WIDTH, 4, number of ring bits (>=2)
- LOCK_CNT, 2, consecutive correct rotations needed to declare lock (>=1)
- REV_W, 8, width of revolution counter
- ERR_W, 8, width of error counter

Ports:
- c  input  1  clock, rising edge
- rst  input  1  reset, asynchronous, active-low (0 = reset)
- en  input  1  sample enable; when 0 all state holds
- q_in  input  WIDTH  ring state from counter
- idx  output  $clog2(WIDTH)  binary position of hot bit
- onehot_ok  output  1  last sample was exactly one-hot
- locked  output  1  FSM in LOCKED
- err  output  1  one-cycle pulse on sequence error while locked
- err_cnt  output  ERR_W  saturating error count
- wrap  output  1  one-cycle pulse on revolution (bit WIDTH-1 -> bit 0)
- rev_cnt  output  REV_W  revolution count, modulo 2^REV_W

Behaviour:
- Reset (rst=0, async): state=SEARCH, expected=0, good_cnt=0. All outputs are 0: idx, onehot_ok, locked, err, err_cnt, wrap, rev_cnt.
- Rotation rule: next = {s[WIDTH-2:0], s[WIDTH-1]}, so the hot bit moves toward the MSB and wraps to bit 0.
- Sampling and latency:
  - All decisions use q_in at a rising edge where en=1.
  - Outputs are registered and reflect that sample after the same edge (1-cycle latency).
- en=0: state, counters and idx hold. err and wrap are forced to 0.
- One-hot check: onehot_ok = (popcount(q_in)==1).
  - If one-hot, idx = position of the hot bit.
  - Otherwise idx holds its previous value.
- FSM, SEARCH:
  - One-hot sample -> ACQUIRE, expected=rot(sample), good_cnt=0.
  - Non-one-hot sample -> stay in SEARCH.
- FSM, ACQUIRE:
  - sample==expected -> good_cnt+1 and expected=rot(sample). When good_cnt+1==LOCK_CNT -> LOCKED.
  - Mismatch but one-hot -> re-seed: stay in ACQUIRE, expected=rot(sample), good_cnt=0.
  - Non-one-hot -> SEARCH.
  - No err pulse is generated in ACQUIRE.
- FSM, LOCKED:
  - sample==expected -> stay in LOCKED, expected=rot(sample).
  - Mismatch (including a held/stuck value or non-one-hot) -> err=1 for one cycle, err_cnt+1 saturating at 2^ERR_W-1, go to SEARCH, good_cnt=0.
- Wrap: in LOCKED, a matching sample with bit0=1 (previous sample was bit WIDTH-1) -> wrap=1 for one cycle and rev_cnt+1, wrapping from max to 0.
  - The entry into LOCKED does not itself count as a wrap.
- Simultaneous events: an error has priority; a mismatching sample never produces wrap.
- Reset mid-operation clears everything immediately, with no wait for a clock edge. Deassertion is used synchronously by the testbench driver.

Decomposition:
- Shared package ring_pkg:
  - FSM state encoding (SEARCH=2'd0, ACQUIRE=2'd1, LOCKED=2'd2)
  - Default WIDTH constant
  - Rotation function
- Sub-module onehot_decode (combinational): input WIDTH vector; outputs valid and binary index. It is reusable by other ring consumers.
- FSM and counters stay in ring_sequence_monitor.

Test Plan:
- Reset: hold rst=0 for 50 ns with random q_in -> all outputs 0; release -> still 0 until first enabled sample.
- Lock-in (WIDTH=4, LOCK_CNT=2, en=1): feed 0001, 0010, 0100 ->
  - idx = 0, 1, 2
  - locked=1 after the 0100 edge
  - err=0 throughout
- Wrap: continue with 1000, 0001 -> wrap=1 for exactly one cycle on the 0001 edge, rev_cnt=1, idx=0; repeating 4 more samples gives rev_cnt=2.
- Sequence error: while locked and expecting 0010, feed 0100 ->
  - err pulse for 1 cycle, err_cnt=1, locked=0
  - next samples 1000, 0001, 0010 -> re-lock
- Illegal codes and hold:
  - Feed 0011 -> onehot_ok=0, idx holds its previous value.
  - In SEARCH, 0000 keeps the FSM in SEARCH.
  - en=0 for 3 cycles with a changing q_in -> no state change.
- Saturation and async reset: force 260 errors -> err_cnt stops at 255. Assert rst mid-LOCKED between clock edges -> locked, err_cnt and rev_cnt go to 0 immediately.

Source files
------------

// File: rtl/ring_pkg.sv
// Shared definitions for one-hot ring counter consumers: FSM encoding,
// default ring width and the rotation step.
package ring_pkg;

    localparam int DEFAULT_WIDTH = 4;
    localparam int MAX_RING_W    = 32;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } ring_state_e;

    // Hot bit moves toward the MSB and wraps to bit 0; s must be zero above width.
    function automatic logic [MAX_RING_W-1:0] ring_rot(input logic [MAX_RING_W-1:0] s,
                                                       input int width);
        logic [MAX_RING_W-1:0] mask;
        mask = ~({MAX_RING_W{1'b1}} << width);
        return ((s << 1) | (s >> (width - 1))) & mask;
    endfunction

endpackage

// File: rtl/onehot_decode.sv
// Combinational one-hot checker: valid when exactly one bit is set, index is
// the binary position of that bit.
module onehot_decode
    import ring_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0]         vec_i,
    output logic                     valid_o,
    output logic [$clog2(WIDTH)-1:0] index_o
);

    localparam int IDX_W = $clog2(WIDTH);

    int ones;

    always_comb begin
        ones    = 0;
        index_o = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (vec_i[i]) begin
                ones    = ones + 1;
                index_o = IDX_W'(i);
            end
        end
        valid_o = (ones == 1);
    end

endmodule

// File: rtl/ring_sequence_monitor.sv
// Receive-side monitor for a one-hot ring counter: checks legal rotation,
// decodes the hot position and counts revolutions and sequence errors.
module ring_sequence_monitor
    import ring_pkg::*;
#(
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int LOCK_CNT = 2,
    parameter int REV_W    = 8,
    parameter int ERR_W    = 8
) (
    input  logic                     c,
    input  logic                     rst,
    input  logic                     en,
    input  logic [WIDTH-1:0]         q_in,
    output logic [$clog2(WIDTH)-1:0] idx,
    output logic                     onehot_ok,
    output logic                     locked,
    output logic                     err,
    output logic [ERR_W-1:0]         err_cnt,
    output logic                     wrap,
    output logic [REV_W-1:0]         rev_cnt,
    output logic [1:0]               dbg_state_o
);

    localparam int IDX_W  = $clog2(WIDTH);
    localparam int GOOD_W = $clog2(LOCK_CNT + 1);

    ring_state_e       state_q, state_d;
    logic [WIDTH-1:0]  expected_q, expected_d;
    logic [GOOD_W-1:0] good_q, good_d, good_inc;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              ok_q, ok_d;
    logic              err_q, err_d;
    logic              wrap_q, wrap_d;
    logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;
    logic [REV_W-1:0]  rev_q, rev_d;

    logic              dec_valid;
    logic [IDX_W-1:0]  dec_idx;
    logic [WIDTH-1:0]  rot_sample;

    onehot_decode #(.WIDTH(WIDTH)) u_decode (
        .vec_i   (q_in),
        .valid_o (dec_valid),
        .index_o (dec_idx)
    );

    assign rot_sample = WIDTH'(ring_rot(MAX_RING_W'(q_in), WIDTH));
    assign good_inc   = good_q + GOOD_W'(1);

    always_comb begin
        state_d    = state_q;
        expected_d = expected_q;
        good_d     = good_q;
        idx_d      = idx_q;
        ok_d       = ok_q;
        err_d      = 1'b0;
        wrap_d     = 1'b0;
        err_cnt_d  = err_cnt_q;
        rev_d      = rev_q;
        if (en) begin
            ok_d = dec_valid;
            if (dec_valid) idx_d = dec_idx;
            unique case (state_q)
                SEARCH: begin
                    if (dec_valid) begin
                        state_d    = ACQUIRE;
                        expected_d = rot_sample;
                        good_d     = '0;
                    end
                end
                ACQUIRE: begin
                    if (q_in == expected_q) begin
                        good_d     = good_inc;
                        expected_d = rot_sample;
                        if (good_inc == GOOD_W'(LOCK_CNT)) state_d = LOCKED;
                    end else if (dec_valid) begin
                        // A legal but unexpected code restarts acquisition from it.
                        expected_d = rot_sample;
                        good_d     = '0;
                    end else begin
                        state_d = SEARCH;
                        good_d  = '0;
                    end
                end
                LOCKED: begin
                    if (q_in == expected_q) begin
                        expected_d = rot_sample;
                        if (q_in[0]) begin
                            wrap_d = 1'b1;
                            rev_d  = rev_q + REV_W'(1);
                        end
                    end else begin
                        err_d   = 1'b1;
                        state_d = SEARCH;
                        good_d  = '0;
                        if (err_cnt_q != {ERR_W{1'b1}}) err_cnt_d = err_cnt_q + ERR_W'(1);
                    end
                end
                default: state_d = SEARCH;
            endcase
        end
    end

    always_ff @(posedge c or negedge rst) begin
        if (!rst) begin
            state_q    <= SEARCH;
            expected_q <= '0;
            good_q     <= '0;
            idx_q      <= '0;
            ok_q       <= 1'b0;
            err_q      <= 1'b0;
            wrap_q     <= 1'b0;
            err_cnt_q  <= '0;
            rev_q      <= '0;
        end else begin
            state_q    <= state_d;
            expected_q <= expected_d;
            good_q     <= good_d;
            idx_q      <= idx_d;
            ok_q       <= ok_d;
            err_q      <= err_d;
            wrap_q     <= wrap_d;
            err_cnt_q  <= err_cnt_d;
            rev_q      <= rev_d;
        end
    end

    assign idx         = idx_q;
    assign onehot_ok   = ok_q;
    assign locked      = (state_q == LOCKED);
    assign err         = err_q;
    assign err_cnt     = err_cnt_q;
    assign wrap        = wrap_q;
    assign rev_cnt     = rev_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ring_sequence_monitor.sv
// Bench for ring_sequence_monitor: directed vector table, saturation and
// async-reset sequences, then random traffic against a chain-length model.
module tb_ring_sequence_monitor;

    localparam int WIDTH    = 4;
    localparam int LOCK_CNT = 2;
    localparam int W        = 22;

    logic       c = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic [3:0] q_in = 4'b0;
    logic [1:0] idx;
    logic       onehot_ok, locked, err, wrap;
    logic [7:0] err_cnt, rev_cnt;
    logic [1:0] dbg_state;

    ring_sequence_monitor #(.WIDTH(WIDTH), .LOCK_CNT(LOCK_CNT), .REV_W(8), .ERR_W(8)) dut (
        .c           (c),
        .rst         (rst),
        .en          (en),
        .q_in        (q_in),
        .idx         (idx),
        .onehot_ok   (onehot_ok),
        .locked      (locked),
        .err         (err),
        .err_cnt     (err_cnt),
        .wrap        (wrap),
        .rev_cnt     (rev_cnt),
        .dbg_state_o (dbg_state)
    );

    // clock / reset
    always #5 c = ~c;

    int checks = 0;
    int errors = 0;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic       en;
        logic [3:0] q;
        logic [1:0] idx;
        logic       ok, lk, er;
        logic [7:0] ec;
        logic       wr;
        logic [7:0] rv;
    } vec_t;

    vec_t vq[$];
    logic [W-1:0] exp_q[$];

    task automatic add(input logic e, input logic [3:0] q, input logic [1:0] i, input logic ok,
                       input logic lk, input logic er, input logic [7:0] ec, input logic wr,
                       input logic [7:0] rv);
        vec_t v;
        v = '{e, q, i, ok, lk, er, ec, wr, rv};
        vq.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [1:0] e_idx, input logic e_ok,
                           input logic e_lk, input logic e_er, input logic [7:0] e_ec,
                           input logic e_wr, input logic [7:0] e_rv);
        chk({tag, " idx"}, 32'(idx), 32'(e_idx));
        chk({tag, " onehot_ok"}, 32'(onehot_ok), 32'(e_ok));
        chk({tag, " locked"}, 32'(locked), 32'(e_lk));
        chk({tag, " err"}, 32'(err), 32'(e_er));
        chk({tag, " err_cnt"}, 32'(err_cnt), 32'(e_ec));
        chk({tag, " wrap"}, 32'(wrap), 32'(e_wr));
        chk({tag, " rev_cnt"}, 32'(rev_cnt), 32'(e_rv));
    endtask

    // driver: inputs change on the falling edge, outputs sampled 1 ns after rising edge
    task automatic drive(input logic e, input logic [3:0] q);
        @(negedge c);
        en   = e;
        q_in = q;
        @(posedge c);
        #1;
    endtask

    task automatic pulse_reset();
        @(negedge c);
        rst = 1'b0;
        en  = 1'b0;
        @(negedge c);
        rst = 1'b1;
    endtask

    // reference model: tracks how many consecutive correctly rotated one-hot samples
    // have been seen; lock when that chain reaches LOCK_CNT rotations
    int         m_chain;
    logic [3:0] m_prev;
    logic [1:0] m_idx;
    logic       m_ok, m_lk, m_er, m_wr;
    logic [7:0] m_ec, m_rv;

    function automatic logic [3:0] rotf(input logic [3:0] s);
        int v;
        v = int'(s);
        return 4'(((v * 2) % 16) + (v / 8));
    endfunction

    task automatic model_reset();
        m_chain = -1; m_prev = '0; m_idx = '0; m_ok = 0; m_lk = 0;
        m_er = 0; m_wr = 0; m_ec = '0; m_rv = '0;
    endtask

    task automatic model_step(input logic e, input logic [3:0] q);
        m_er = 0;
        m_wr = 0;
        if (e) begin
            m_ok = ($countones(q) == 1);
            if (m_ok) m_idx = 2'($clog2(q));
            if (m_lk) begin
                if (q == rotf(m_prev)) begin
                    if (q[0]) begin
                        m_wr = 1;
                        m_rv = m_rv + 8'd1;
                    end
                end else begin
                    m_er = 1;
                    if (m_ec != 8'hFF) m_ec = m_ec + 8'd1;
                    m_lk = 0;
                    m_chain = -1;
                end
            end else if (m_ok) begin
                if (m_chain >= 0 && q == rotf(m_prev)) m_chain++;
                else m_chain = 0;
                if (m_chain == LOCK_CNT) m_lk = 1;
            end else begin
                m_chain = -1;
            end
            m_prev = q;
        end
    endtask

    initial begin
        logic [3:0] q_r, last_q;
        logic       e_r;
        logic [W-1:0] got, expv;

        // reset held with random input activity
        rst = 1'b0;
        repeat (5) begin
            @(negedge c);
            en   = 1'b1;
            q_in = 4'($urandom);
            @(posedge c);
            #1;
            chk_all("in_reset", 2'd0, 0, 0, 0, 8'd0, 0, 8'd0);
        end
        chk("in_reset state", 32'(dbg_state), 32'd0);
        @(negedge c);
        rst = 1'b1;
        en  = 1'b0;
        @(posedge c);
        #1;
        chk_all("post_reset", 2'd0, 0, 0, 0, 8'd0, 0, 8'd0);

        // directed table: lock, wraps, sequence error, relock, illegal codes, enable hold
        add(1, 4'b0001, 0, 1, 0, 0, 8'd0, 0, 8'd0);
        add(1, 4'b0010, 1, 1, 0, 0, 8'd0, 0, 8'd0);
        add(1, 4'b0100, 2, 1, 1, 0, 8'd0, 0, 8'd0);
        add(1, 4'b1000, 3, 1, 1, 0, 8'd0, 0, 8'd0);
        add(1, 4'b0001, 0, 1, 1, 0, 8'd0, 1, 8'd1);
        add(1, 4'b0010, 1, 1, 1, 0, 8'd0, 0, 8'd1);
        add(1, 4'b0100, 2, 1, 1, 0, 8'd0, 0, 8'd1);
        add(1, 4'b1000, 3, 1, 1, 0, 8'd0, 0, 8'd1);
        add(1, 4'b0001, 0, 1, 1, 0, 8'd0, 1, 8'd2);
        add(1, 4'b0100, 2, 1, 0, 1, 8'd1, 0, 8'd2);
        add(1, 4'b1000, 3, 1, 0, 0, 8'd1, 0, 8'd2);
        add(1, 4'b0001, 0, 1, 0, 0, 8'd1, 0, 8'd2);
        add(1, 4'b0010, 1, 1, 1, 0, 8'd1, 0, 8'd2);
        add(1, 4'b0011, 1, 0, 0, 1, 8'd2, 0, 8'd2);
        add(1, 4'b0000, 1, 0, 0, 0, 8'd2, 0, 8'd2);
        add(1, 4'b0100, 2, 1, 0, 0, 8'd2, 0, 8'd2);
        add(0, 4'b1000, 2, 1, 0, 0, 8'd2, 0, 8'd2);
        add(0, 4'b0011, 2, 1, 0, 0, 8'd2, 0, 8'd2);
        add(0, 4'b0001, 2, 1, 0, 0, 8'd2, 0, 8'd2);
        add(1, 4'b1000, 3, 1, 0, 0, 8'd2, 0, 8'd2);
        add(1, 4'b0001, 0, 1, 1, 0, 8'd2, 0, 8'd2);
        add(0, 4'b0100, 0, 1, 1, 0, 8'd2, 0, 8'd2);
        add(1, 4'b0010, 1, 1, 1, 0, 8'd2, 0, 8'd2);
        add(1, 4'b0010, 1, 1, 0, 1, 8'd3, 0, 8'd2);
        add(0, 4'b0100, 1, 1, 0, 0, 8'd3, 0, 8'd2);
        foreach (vq[i]) begin
            drive(vq[i].en, vq[i].q);
            chk_all($sformatf("vec[%0d]", i), vq[i].idx, vq[i].ok, vq[i].lk, vq[i].er,
                    vq[i].ec, vq[i].wr, vq[i].rv);
        end

        // error counter saturation: lock then stall, 260 times
        for (int n = 0; n < 260; n++) begin
            drive(1, 4'b0001);
            drive(1, 4'b0010);
            drive(1, 4'b0100);
            drive(1, 4'b0100);
        end
        chk("sat err", 32'(err), 32'd1);
        chk("sat err_cnt", 32'(err_cnt), 32'd255);
        chk("sat locked", 32'(locked), 32'd0);
        chk("sat rev_cnt", 32'(rev_cnt), 32'd2);

        // async reset between clock edges while locked
        drive(1, 4'b0001);
        drive(1, 4'b0010);
        drive(1, 4'b0100);
        drive(1, 4'b1000);
        drive(1, 4'b0001);
        chk_all("pre_async", 2'd0, 1, 1, 0, 8'd255, 1, 8'd3);
        chk("pre_async state", 32'(dbg_state), 32'd2);
        #2;
        rst = 1'b0;
        #1;
        chk_all("async_rst", 2'd0, 0, 0, 0, 8'd0, 0, 8'd0);
        @(negedge c);
        rst = 1'b1;

        // random traffic against the reference model
        pulse_reset();
        model_reset();
        last_q = 4'b0001;
        for (int i = 0; i < 2000; i++) begin
            int r;
            r   = int'($urandom_range(0, 99));
            e_r = ($urandom_range(0, 9) != 0);
            if (r < 70)      q_r = rotf(last_q);
            else if (r < 80) q_r = last_q;
            else if (r < 90) q_r = 4'(1 << $urandom_range(0, 3));
            else             q_r = 4'($urandom);
            if (e_r) last_q = q_r;
            model_step(e_r, q_r);
            exp_q.push_back({m_idx, m_ok, m_lk, m_er, m_ec, m_wr, m_rv});
            drive(e_r, q_r);
            got  = {idx, onehot_ok, locked, err, err_cnt, wrap, rev_cnt};
            expv = exp_q.pop_front();
            chk($sformatf("rand[%0d] {idx,ok,lk,err,ec,wrap,rev}", i), 32'(got), 32'(expv));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
